operand_fetch: RTL and testbench

- Parametrised operand-address sequencer for the 6502 core, successor to the current hard-wired fetch FSM.
- Accepts a decoded opcode, walks all eight group-01/group-10 addressing modes, and generates effective addresses with zero-page wrap, indexed page-cross fix-up and indirect pointer fetch.
- Returns one operand byte per instruction over a valid handshake.
- Sits between the PC/opcode latch and the register/ALU stage; talks to memory through a req/ack port that tolerates wait states.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/idx_add8.sv | 11 +
 rtl/operand_fetch.sv | 196 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared 6502 operand-fetch encodings: addressing modes, groups, FSM states.
package cpu_pkg;

    localparam logic [2:0] AM_ZP_X_IN = 3'b000;
    localparam logic [2:0] AM_ZP      = 3'b001;
    localparam logic [2:0] AM_IMM     = 3'b010;
    localparam logic [2:0] AM_ABS     = 3'b011;
    localparam logic [2:0] AM_ZP_IN_Y = 3'b100;
    localparam logic [2:0] AM_ZP_X    = 3'b101;
    localparam logic [2:0] AM_ABS_Y   = 3'b110;
    localparam logic [2:0] AM_ABS_X   = 3'b111;

    typedef enum logic [1:0] {
        GRP_00 = 2'b00,
        GRP_01 = 2'b01,
        GRP_10 = 2'b10,
        GRP_11 = 2'b11
    } group_t;

    typedef enum logic [6:0] {
        ST_IDLE = 7'b000_0001,
        ST_LO   = 7'b000_0010,
        ST_HI   = 7'b000_0100,
        ST_PLO  = 7'b000_1000,
        ST_PHI  = 7'b001_0000,
        ST_FIX  = 7'b010_0000,
        ST_RD   = 7'b100_0000
    } state_t;

    typedef enum logic [2:0] {
        K_IMM, K_ZP, K_ZP_IDX, K_IND_X, K_IND_Y, K_ABS, K_ABS_IDX
    } kind_t;

    // Collapses the eight amodes of both groups into the fetch sequence they need.
    function automatic kind_t amode_kind(input logic [2:0] am, input group_t grp);
        unique case (am)
            AM_ZP_X_IN: return (grp == GRP_10) ? K_IMM : K_IND_X;
            AM_ZP:      return K_ZP;
            AM_IMM:     return K_IMM;
            AM_ABS:     return K_ABS;
            AM_ZP_IN_Y: return K_IND_Y;
            AM_ZP_X:    return K_ZP_IDX;
            AM_ABS_Y:   return K_ABS_IDX;
            AM_ABS_X:   return K_ABS_IDX;
            default:    return K_IMM;
        endcase
    endfunction

    function automatic logic amode_uses_y(input logic [2:0] am, input group_t grp);
        return (am == AM_ZP_IN_Y) || (am == AM_ABS_Y) ||
               ((grp == GRP_10) && ((am == AM_ZP_X) || (am == AM_ABS_X)));
    endfunction

endpackage

// File: rtl/idx_add8.sv
// rtl/idx_add8.sv - 8-bit base plus index adder with carry into the high byte.
module idx_add8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o,
    output logic       carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - 6502 operand-address sequencer over a wait-state tolerant req/ack port.
// DUMMY_READ_EN makes the page-cross fix-up cycle issue a real read at the uncorrected address.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int         ADDR_W  = 16,
    parameter int         BANK    = 0,
    parameter logic [7:0] ZP_PAGE = 8'h00
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              op_valid,
    input  logic [7:0]        op_in,
    output logic              op_ready,
    input  logic [15:0]       pc,
    output logic              pc_inc,
    input  logic [7:0]        x_reg,
    input  logic [7:0]        y_reg,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              opnd_valid,
    output logic [7:0]        opnd_data,
    output logic [15:0]       opnd_addr,
    output logic              page_cross
);

    state_t      state_q;
    kind_t       kind_q;
    logic        use_y_q;
    logic [15:0] pc_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic [7:0]  ptr_q;
    logic [7:0]  sum_q;
    logic [15:0] addr_q;
    logic        op_ready_q;
    logic        mem_req_q;
    logic        pc_inc_q;
    logic        opnd_valid_q;
    logic [7:0]  opnd_data_q;
    logic [15:0] opnd_addr_q;
    logic        page_cross_q;

    logic [7:0]  idx_val;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_carry;
    logic        fix_done;
    logic        unused_op_bits;

    assign unused_op_bits = ^op_in[7:5];
    assign idx_val        = use_y_q ? y_reg : x_reg;

`ifdef DUMMY_READ_EN
    assign fix_done = mem_ack;
`else
    assign fix_done = 1'b1;
`endif

    // One adder serves every state; only the operands it sees change.
    always_comb begin
        add_a = lo_q;
        add_b = 8'h00;
        unique case (state_q)
            ST_LO: begin
                add_a = mem_rdata;
                if (kind_q == K_ZP_IDX || kind_q == K_IND_X) add_b = idx_val;
            end
            ST_HI:   if (kind_q == K_ABS_IDX) add_b = idx_val;
            ST_PHI:  if (kind_q == K_IND_Y) add_b = idx_val;
            default: add_b = 8'h00;
        endcase
    end

    idx_add8 u_idx_add8 (
        .a_i     (add_a),
        .b_i     (add_b),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q      <= ST_IDLE;
            kind_q       <= K_IMM;
            use_y_q      <= 1'b0;
            pc_q         <= 16'h0000;
            lo_q         <= 8'h00;
            hi_q         <= 8'h00;
            ptr_q        <= 8'h00;
            sum_q        <= 8'h00;
            addr_q       <= 16'h0000;
            op_ready_q   <= 1'b1;
            mem_req_q    <= 1'b0;
            pc_inc_q     <= 1'b0;
            opnd_valid_q <= 1'b0;
            opnd_data_q  <= 8'h00;
            opnd_addr_q  <= 16'h0000;
            page_cross_q <= 1'b0;
        end else begin
            pc_inc_q     <= 1'b0;
            opnd_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: if (op_valid && op_ready_q) begin
                    kind_q       <= amode_kind(op_in[4:2], group_t'(op_in[1:0]));
                    use_y_q      <= amode_uses_y(op_in[4:2], group_t'(op_in[1:0]));
                    pc_q         <= pc;
                    addr_q       <= pc;
                    mem_req_q    <= 1'b1;
                    op_ready_q   <= 1'b0;
                    page_cross_q <= 1'b0;
                    state_q      <= ST_LO;
                end
                ST_LO: if (mem_ack) begin
                    pc_inc_q <= 1'b1;
                    lo_q     <= mem_rdata;
                    unique case (kind_q)
                        K_IMM: begin
                            opnd_data_q  <= mem_rdata;
                            opnd_addr_q  <= pc_q;
                            opnd_valid_q <= 1'b1;
                            op_ready_q   <= 1'b1;
                            mem_req_q    <= 1'b0;
                            state_q      <= ST_IDLE;
                        end
                        K_ZP, K_ZP_IDX: begin
                            addr_q  <= {ZP_PAGE, add_sum};
                            state_q <= ST_RD;
                        end
                        K_IND_X, K_IND_Y: begin
                            ptr_q   <= add_sum;
                            addr_q  <= {ZP_PAGE, add_sum};
                            state_q <= ST_PLO;
                        end
                        default: begin
                            addr_q  <= pc_q + 16'd1;
                            state_q <= ST_HI;
                        end
                    endcase
                end
                ST_PLO: if (mem_ack) begin
                    lo_q    <= mem_rdata;
                    addr_q  <= {ZP_PAGE, ptr_q + 8'd1};
                    state_q <= ST_PHI;
                end
                // High byte arrives here for both absolute and indirect forms.
                ST_HI, ST_PHI: if (mem_ack) begin
                    pc_inc_q <= (state_q == ST_HI);
                    hi_q     <= mem_rdata;
                    sum_q    <= add_sum;
                    addr_q   <= {mem_rdata, add_sum};
                    if (add_carry) begin
                        state_q <= ST_FIX;
`ifndef DUMMY_READ_EN
                        mem_req_q <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_RD;
                    end
                end
                ST_FIX: if (fix_done) begin
                    page_cross_q <= 1'b1;
                    mem_req_q    <= 1'b1;
                    addr_q       <= {hi_q + 8'd1, sum_q};
                    state_q      <= ST_RD;
                end
                ST_RD: if (mem_ack) begin
                    opnd_data_q  <= mem_rdata;
                    opnd_addr_q  <= addr_q;
                    opnd_valid_q <= 1'b1;
                    op_ready_q   <= 1'b1;
                    mem_req_q    <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_req_q  <= 1'b0;
                    op_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready   = op_ready_q;
    assign pc_inc     = pc_inc_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = ADDR_W'((64'(BANK) << 16) | 64'(addr_q));
    assign opnd_valid = opnd_valid_q;
    assign opnd_data  = opnd_data_q;
    assign opnd_addr  = opnd_addr_q;
    assign page_cross = page_cross_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch against an address-arithmetic model.
module tb_operand_fetch;

    logic        CLK = 1'b0;
    logic        R = 1'b1;
    logic        op_valid = 1'b0;
    logic [7:0]  op_in = 8'h00;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  x_reg = 8'h00;
    logic [7:0]  y_reg = 8'h00;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        op_ready, pc_inc, mem_req, opnd_valid, page_cross;
    logic [15:0] mem_addr, opnd_addr;
    logic [7:0]  opnd_data;

    operand_fetch dut (
        .CLK(CLK), .R(R), .op_valid(op_valid), .op_in(op_in), .op_ready(op_ready),
        .pc(pc), .pc_inc(pc_inc), .x_reg(x_reg), .y_reg(y_reg),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .opnd_valid(opnd_valid), .opnd_data(opnd_data), .opnd_addr(opnd_addr),
        .page_cross(page_cross)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  mem [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;
    int          mem_delay = 0, wait_cnt = 0;
    int          pcinc_cnt = 0, valid_cnt = 0, unstable_cnt = 0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  cap_data = 8'h00;
    logic [15:0] cap_addr = 16'h0000;
    logic        cap_cross = 1'b0;
    logic [15:0] obs_reads[$];
    logic [15:0] exp_reads[$];
    logic [7:0]  exp_data;
    logic [15:0] exp_addr;
    logic        exp_cross;
    int          exp_pcinc;

    // Memory responder and strobe monitor, both on the falling edge.
    initial forever begin
        @(negedge CLK);
        if (pc_inc) pcinc_cnt++;
        if (opnd_valid) begin
            valid_cnt++;
            cap_data  = opnd_data;
            cap_addr  = opnd_addr;
            cap_cross = page_cross;
        end
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt == 0) begin
                req_addr = mem_addr;
                obs_reads.push_back(mem_addr);
            end else if (mem_addr !== req_addr) begin
                unstable_cnt++;
            end
            if (wait_cnt >= mem_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic bit reads_match();
        if (obs_reads.size() != exp_reads.size()) return 1'b0;
        foreach (obs_reads[i]) if (obs_reads[i] !== exp_reads[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic exec_op(input logic [7:0] op, input logic [15:0] p,
                           input logic [7:0] x, input logic [7:0] y, input int dly);
        int t;
        mem_delay = dly; x_reg = x; y_reg = y; pc = p;
        t = 0;
        while (!op_ready && t < 50) begin @(negedge CLK); t++; end
        obs_reads.delete(); pcinc_cnt = 0; valid_cnt = 0; unstable_cnt = 0;
        op_in = op; op_valid = 1'b1;
        @(negedge CLK);
        op_valid = 1'b0;
        t = 0;
        while (valid_cnt == 0 && t < 300) begin @(negedge CLK); t++; end
        repeat (3) @(negedge CLK);
        #1;
        if (t >= 300) begin
            n_checks++; n_errors++;
            $display("FAIL timeout op=%h: no opnd_valid within 300 cycles", op);
        end
    endtask

    // Expected behaviour straight from the addressing-mode arithmetic.
    task automatic model(input logic [7:0] op, input logic [15:0] p,
                         input logic [7:0] x, input logic [7:0] y);
        logic [2:0]  am;
        logic [1:0]  grp;
        logic [7:0]  b, ix, zp, ad;
        logic [15:0] base, p1;
        int          lo_sum;
        bit          is_imm;
        am = op[4:2]; grp = op[1:0]; b = mem[p]; p1 = p + 16'd1;
        ix = (am == 3'd4 || am == 3'd6 || (grp == 2'd2 && (am == 3'd5 || am == 3'd7))) ? y : x;
        exp_reads.delete(); exp_reads.push_back(p);
        exp_cross = 1'b0; exp_pcinc = 1;
        is_imm = (am == 3'd2) || (am == 3'd0 && grp == 2'd2);
        if (is_imm) exp_addr = p;
        else if (am == 3'd1) exp_addr = {8'h00, b};
        else if (am == 3'd5) begin zp = b + ix; exp_addr = {8'h00, zp}; end
        else if (am == 3'd0) begin
            zp = b + x; ad = zp + 8'd1;
            exp_reads.push_back({8'h00, zp}); exp_reads.push_back({8'h00, ad});
            exp_addr = {mem[{8'h00, ad}], mem[{8'h00, zp}]};
        end else begin
            if (am == 3'd4) begin
                ad = b + 8'd1;
                exp_reads.push_back({8'h00, b}); exp_reads.push_back({8'h00, ad});
                base = {mem[{8'h00, ad}], mem[{8'h00, b}]};
            end else begin
                exp_reads.push_back(p1);
                base = {mem[p1], b};
                exp_pcinc = 2;
            end
            if (am == 3'd3) ix = 8'h00;
            lo_sum    = int'(base[7:0]) + int'(ix);
            exp_addr  = base + {8'h00, ix};
            exp_cross = (lo_sum > 255);
`ifdef DUMMY_READ_EN
            if (exp_cross) exp_reads.push_back({base[15:8], exp_addr[7:0]});
`endif
        end
        if (!is_imm) exp_reads.push_back(exp_addr);
        exp_data = mem[exp_addr];
    endtask

    task automatic test_reset();
        n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_checks++; if (pc_inc !== 1'b0 || opnd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_strobes got=%b%b exp=00", pc_inc, opnd_valid); end
        n_checks++; if (opnd_data !== 8'h00 || opnd_addr !== 16'h0000) begin n_errors++; $display("FAIL reset_opnd got=%h/%h exp=00/0000", opnd_data, opnd_addr); end
        n_checks++; if (page_cross !== 1'b0 || mem_addr !== 16'h0000) begin n_errors++; $display("FAIL reset_misc got=%b/%h exp=0/0000", page_cross, mem_addr); end
    endtask

    task automatic test_imm();
        mem[16'h0200] = 8'h42;
        exp_reads = '{16'h0200};
        exec_op(8'hA9, 16'h0200, 8'h00, 8'h00, 0);
        n_checks++; if (valid_cnt !== 1) begin n_errors++; $display("FAIL imm_valid_cnt got=%0d exp=1", valid_cnt); end
        n_checks++; if (cap_data !== 8'h42 || cap_addr !== 16'h0200) begin n_errors++; $display("FAIL imm_operand got=%h@%h exp=42@0200", cap_data, cap_addr); end
        n_checks++; if (pcinc_cnt !== 1) begin n_errors++; $display("FAIL imm_pc_inc got=%0d exp=1", pcinc_cnt); end
        n_checks++; if (!reads_match()) begin n_errors++; $display("FAIL imm_reads got=%0d reads exp=%0d", obs_reads.size(), exp_reads.size()); end
    endtask

    task automatic test_zp_x();
        mem[16'h0210] = 8'hF0; mem[16'h0010] = 8'h5C;
        exp_reads = '{16'h0210, 16'h0010};
        exec_op(8'hB5, 16'h0210, 8'h20, 8'h00, 0);
        n_checks++; if (cap_addr !== 16'h0010 || cap_data !== 8'h5C) begin n_errors++; $display("FAIL zpx_operand got=%h@%h exp=5C@0010", cap_data, cap_addr); end
        n_checks++; if (cap_cross !== 1'b0) begin n_errors++; $display("FAIL zpx_page_cross got=%b exp=0", cap_cross); end
        n_checks++; if (!reads_match()) begin n_errors++; $display("FAIL zpx_reads got=%0d reads exp=%0d", obs_reads.size(), exp_reads.size()); end
    endtask

    task automatic test_abs_x_cross();
        mem[16'h0220] = 8'hFF; mem[16'h0221] = 8'h12; mem[16'h1300] = 8'hA5; mem[16'h1200] = 8'h11;
`ifdef DUMMY_READ_EN
        exp_reads = '{16'h0220, 16'h0221, 16'h1200, 16'h1300};
`else
        exp_reads = '{16'h0220, 16'h0221, 16'h1300};
`endif
        exec_op(8'hBD, 16'h0220, 8'h01, 8'h00, 0);
        n_checks++; if (pcinc_cnt !== 2) begin n_errors++; $display("FAIL absx_pc_inc got=%0d exp=2", pcinc_cnt); end
        n_checks++; if (cap_addr !== 16'h1300 || cap_data !== 8'hA5) begin n_errors++; $display("FAIL absx_operand got=%h@%h exp=A5@1300", cap_data, cap_addr); end
        n_checks++; if (cap_cross !== 1'b1) begin n_errors++; $display("FAIL absx_page_cross got=%b exp=1", cap_cross); end
        n_checks++; if (!reads_match()) begin n_errors++; $display("FAIL absx_reads got=%0d reads exp=%0d", obs_reads.size(), exp_reads.size()); end
    endtask

    task automatic test_ind_y();
        mem[16'h0230] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12; mem[16'h1244] = 8'h77;
        exp_reads = '{16'h0230, 16'h00FF, 16'h0000, 16'h1244};
        exec_op(8'hB1, 16'h0230, 8'h00, 8'h10, 0);
        n_checks++; if (cap_addr !== 16'h1244 || cap_data !== 8'h77) begin n_errors++; $display("FAIL indy_operand got=%h@%h exp=77@1244", cap_data, cap_addr); end
        n_checks++; if (cap_cross !== 1'b0) begin n_errors++; $display("FAIL indy_page_cross got=%b exp=0", cap_cross); end
        n_checks++; if (!reads_match()) begin n_errors++; $display("FAIL indy_reads got=%0d reads exp=%0d", obs_reads.size(), exp_reads.size()); end
    endtask

    task automatic test_ind_x_wait();
        mem[16'h0240] = 8'h10; mem[16'h0015] = 8'h78; mem[16'h0016] = 8'h56; mem[16'h5678] = 8'h9A;
        exp_reads = '{16'h0240, 16'h0015, 16'h0016, 16'h5678};
        exec_op(8'hA1, 16'h0240, 8'h05, 8'h00, 3);
        n_checks++; if (unstable_cnt !== 0) begin n_errors++; $display("FAIL indx_addr_stable got=%0d changes exp=0", unstable_cnt); end
        n_checks++; if (valid_cnt !== 1 || pcinc_cnt !== 1) begin n_errors++; $display("FAIL indx_strobes got=%0d/%0d exp=1/1", valid_cnt, pcinc_cnt); end
        n_checks++; if (cap_addr !== 16'h5678 || cap_data !== 8'h9A) begin n_errors++; $display("FAIL indx_operand got=%h@%h exp=9A@5678", cap_data, cap_addr); end
        n_checks++; if (!reads_match()) begin n_errors++; $display("FAIL indx_reads got=%0d reads exp=%0d", obs_reads.size(), exp_reads.size()); end
    endtask

    task automatic test_reset_mid();
        int t;
        mem[16'h0400] = 8'h00; mem[16'h0401] = 8'h30;
        mem_delay = 3; x_reg = 8'h00; pc = 16'h0400;
        obs_reads.delete();
        op_in = 8'hBD; op_valid = 1'b1;
        @(negedge CLK);
        op_valid = 1'b0;
        t = 0;
        while (obs_reads.size() < 2 && t < 100) begin @(negedge CLK); t++; end
        n_checks++; if (t >= 100) begin n_errors++; $display("FAIL rstmid_reach_hi got=%0d reads exp=2", obs_reads.size()); end
        R = 1'b1; valid_cnt = 0; pcinc_cnt = 0;
        @(negedge CLK);
        n_checks++; if (mem_req !== 1'b0 || op_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_req_ready got=%b/%b exp=0/1", mem_req, op_ready); end
        n_checks++; if (pc_inc !== 1'b0 || opnd_valid !== 1'b0 || page_cross !== 1'b0) begin n_errors++; $display("FAIL rstmid_strobes got=%b%b%b exp=000", pc_inc, opnd_valid, page_cross); end
        n_checks++; if (opnd_data !== 8'h00 || opnd_addr !== 16'h0000) begin n_errors++; $display("FAIL rstmid_opnd got=%h/%h exp=00/0000", opnd_data, opnd_addr); end
        @(negedge CLK);
        R = 1'b0;
        repeat (10) @(negedge CLK);
        #1;
        n_checks++; if (valid_cnt !== 0 || pcinc_cnt !== 0) begin n_errors++; $display("FAIL rstmid_no_strobe got=%0d/%0d exp=0/0", valid_cnt, pcinc_cnt); end
        n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_op_ready got=%b exp=1", op_ready); end
    endtask

    task automatic test_back_to_back();
        mem[16'h0500] = 8'h3C;
        mem_delay = 0; pc = 16'h0500;
        valid_cnt = 0; pcinc_cnt = 0;
        op_in = 8'hA9; op_valid = 1'b1;
        repeat (20) @(negedge CLK);
        #1;
        op_valid = 1'b0;
        n_checks++; if (valid_cnt !== 10) begin n_errors++; $display("FAIL b2b_valid_cnt got=%0d exp=10", valid_cnt); end
        n_checks++; if (pcinc_cnt !== 10 || cap_data !== 8'h3C) begin n_errors++; $display("FAIL b2b_pcinc_data got=%0d/%h exp=10/3C", pcinc_cnt, cap_data); end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_random();
        logic [7:0]  op, x, y;
        logic [15:0] p;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            op = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01};
            p = 16'($urandom); x = 8'($urandom); y = 8'($urandom);
            model(op, p, x, y);
            exec_op(op, p, x, y, $urandom_range(0, 2));
            n_checks++; if (valid_cnt !== 1) begin n_errors++; $display("FAIL rnd_valid_cnt op=%h got=%0d exp=1", op, valid_cnt); end
            n_checks++; if (cap_data !== exp_data) begin n_errors++; $display("FAIL rnd_data op=%h got=%h exp=%h", op, cap_data, exp_data); end
            n_checks++; if (cap_addr !== exp_addr) begin n_errors++; $display("FAIL rnd_addr op=%h got=%h exp=%h", op, cap_addr, exp_addr); end
            n_checks++; if (cap_cross !== exp_cross) begin n_errors++; $display("FAIL rnd_page_cross op=%h got=%b exp=%b", op, cap_cross, exp_cross); end
            n_checks++; if (pcinc_cnt !== exp_pcinc) begin n_errors++; $display("FAIL rnd_pc_inc op=%h got=%0d exp=%0d", op, pcinc_cnt, exp_pcinc); end
            n_checks++; if (!reads_match()) begin n_errors++; $display("FAIL rnd_reads op=%h got=%0d reads exp=%0d", op, obs_reads.size(), exp_reads.size()); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge CLK);
        R = 1'b0;
        @(negedge CLK);
        test_reset();
        test_imm();
        test_zp_x();
        test_abs_x_cross();
        test_ind_y();
        test_ind_x_wait();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
